// File: rtl/ps2_key_display_pkg.sv
// Shared constants and lookup helpers for the PS/2 key display block.
package ps2_key_display_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Active-low segment pattern, bit7 = dp kept off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 8'hC0;  4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;  4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;  4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;  4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;  4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;  4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;  4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;  default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: scan_to_ascii = 8'h61;  8'h32: scan_to_ascii = 8'h62;
      8'h21: scan_to_ascii = 8'h63;  8'h23: scan_to_ascii = 8'h64;
      8'h24: scan_to_ascii = 8'h65;  8'h2B: scan_to_ascii = 8'h66;
      8'h34: scan_to_ascii = 8'h67;  8'h33: scan_to_ascii = 8'h68;
      8'h43: scan_to_ascii = 8'h69;  8'h3B: scan_to_ascii = 8'h6A;
      8'h42: scan_to_ascii = 8'h6B;  8'h4B: scan_to_ascii = 8'h6C;
      8'h3A: scan_to_ascii = 8'h6D;  8'h31: scan_to_ascii = 8'h6E;
      8'h44: scan_to_ascii = 8'h6F;  8'h4D: scan_to_ascii = 8'h70;
      8'h15: scan_to_ascii = 8'h71;  8'h2D: scan_to_ascii = 8'h72;
      8'h1B: scan_to_ascii = 8'h73;  8'h2C: scan_to_ascii = 8'h74;
      8'h3C: scan_to_ascii = 8'h75;  8'h2A: scan_to_ascii = 8'h76;
      8'h1D: scan_to_ascii = 8'h77;  8'h22: scan_to_ascii = 8'h78;
      8'h35: scan_to_ascii = 8'h79;  8'h1A: scan_to_ascii = 8'h7A;
      8'h45: scan_to_ascii = 8'h30;  8'h16: scan_to_ascii = 8'h31;
      8'h1E: scan_to_ascii = 8'h32;  8'h26: scan_to_ascii = 8'h33;
      8'h25: scan_to_ascii = 8'h34;  8'h2E: scan_to_ascii = 8'h35;
      8'h36: scan_to_ascii = 8'h36;  8'h3D: scan_to_ascii = 8'h37;
      8'h3E: scan_to_ascii = 8'h38;  8'h46: scan_to_ascii = 8'h39;
      8'h29: scan_to_ascii = 8'h20;
      default: scan_to_ascii = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_display_ps2_rx.sv
// PS/2 frame receiver: synchronizes ps2_clk, shifts bits on falling edges,
// and pulses byte_valid for one cycle on a well-formed 11-bit frame.
module ps2_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [2:0]  sync;
  logic [9:0]  shift;
  logic [3:0]  bit_cnt;
  logic        fall;
  logic [10:0] frame;

  assign fall  = sync[2] & ~sync[1];
  // Completed frame as it would look once the current bit is shifted in.
  assign frame = {ps2_data, shift};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 3'b111;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      sync <= {sync[1:0], ps2_clk};
      if (fall) begin
        shift   <= {ps2_data, shift[9:1]};
        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  assign byte_out   = frame[8:1];
  assign byte_valid = fall && (bit_cnt == 4'd10) && !frame[0] && frame[10]
                      && (^frame[9:1]);

endmodule

// File: rtl/ps2_key_display.sv
// Keyboard front end: decodes PS/2 make/break codes, tracks the held key and
// press count, drives seven-segment digits and a running-light LED bank.
module ps2_key_display
  import ps2_key_display_pkg::*;
#(
  parameter int LED_PERIOD = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [4:0]  btn,
  input  logic [7:0]  sw,
  output logic [15:0] ledr,
  output logic [7:0]  scan_code,
  output logic [7:0]  ascii,
  output logic        key_down,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  localparam int CW = (LED_PERIOD > 2) ? $clog2(LED_PERIOD) : 1;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          break_pending;
  logic [7:0]    press_count;
  logic [7:0]    led;
  logic [CW-1:0] led_cnt;
  logic          unused_btn;

  assign unused_btn = ^btn;

  ps2_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_code     <= '0;
      ascii         <= '0;
      key_down      <= 1'b0;
      press_count   <= '0;
      break_pending <= 1'b0;
    end else if (rx_valid && rx_byte != PS2_EXT) begin
      if (rx_byte == PS2_BREAK) begin
        break_pending <= 1'b1;
      end else if (break_pending) begin
        break_pending <= 1'b0;
        key_down      <= 1'b0;
      end else begin
        scan_code <= rx_byte;
        ascii     <= scan_to_ascii(rx_byte);
        key_down  <= 1'b1;
        // Typematic repeats arrive while held and must not count.
        if (!key_down) press_count <= press_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_cnt <= '0;
      led     <= 8'h01;
    end else if (led_cnt == CW'(LED_PERIOD - 1)) begin
      led_cnt <= '0;
      led     <= {led[6:0], led[7]};
    end else begin
      led_cnt <= led_cnt + 1'b1;
    end
  end

  assign ledr = {led, sw};

  assign seg0 = key_down ? hex_to_seg(scan_code[3:0]) : 8'hFF;
  assign seg1 = key_down ? hex_to_seg(scan_code[7:4]) : 8'hFF;
  assign seg2 = key_down ? hex_to_seg(ascii[3:0])     : 8'hFF;
  assign seg3 = key_down ? hex_to_seg(ascii[7:4])     : 8'hFF;
  assign seg4 = hex_to_seg(press_count[3:0]);
  assign seg5 = hex_to_seg(press_count[7:4]);
  assign seg6 = 8'hFF;
  assign seg7 = 8'hFF;

endmodule

// File: tb/tb_ps2_key_display.sv
// Directed plus randomized bench for ps2_key_display against a behavioural
// key-tracking model.
module tb_ps2_key_display;

  logic        clk = 0;
  logic        rst = 1;
  logic        ps2_clk = 1;
  logic        ps2_data = 1;
  logic [4:0]  btn = '0;
  logic [7:0]  sw = 8'hA5;
  logic [15:0] ledr;
  logic [7:0]  scan_code, ascii;
  logic        key_down;
  logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  int checks = 0;
  int errors = 0;

  ps2_key_display #(.LED_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .btn(btn), .sw(sw), .ledr(ledr), .scan_code(scan_code), .ascii(ascii),
    .key_down(key_down), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,
    8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
    8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,
    8'h3E,8'h46};
  logic [7:0] segtab [16] = '{8'hC0,8'hF9,8'hA4,8'hB0,8'h99,8'h92,8'h82,8'hF8,
    8'h80,8'h90,8'h88,8'h83,8'hC6,8'hA1,8'h86,8'h8E};
  logic [7:0] extras [4] = '{8'h29,8'h05,8'h76,8'h5A};

  logic [7:0] m_scan, m_ascii, m_count;
  logic       m_down, m_break;

  function automatic logic [7:0] model_ascii(input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == b) r = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == b) r = 8'h30 + 8'(i);
    if (b == 8'h29) r = 8'h20;
    return r;
  endfunction

  task automatic model_reset();
    m_scan = 0; m_ascii = 0; m_count = 0; m_down = 0; m_break = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_break = 1; return; end
    if (m_break) begin m_break = 0; m_down = 0; return; end
    m_scan = b; m_ascii = model_ascii(b);
    if (!m_down) m_count = m_count + 8'd1;
    m_down = 1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits of a frame; bad_par inverts the parity bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(8);
      ps2_clk = 0;
      wait_clk(16);
      ps2_clk = 1;
      wait_clk(8);
    end
    ps2_data = 1;
    wait_clk(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".scan"},  {8'h0, scan_code}, {8'h0, m_scan});
    chk({tag, ".ascii"}, {8'h0, ascii},     {8'h0, m_ascii});
    chk({tag, ".down"},  {15'h0, key_down}, {15'h0, m_down});
    chk({tag, ".seg10"}, {seg1, seg0}, m_down ? {segtab[m_scan[7:4]], segtab[m_scan[3:0]]} : 16'hFFFF);
    chk({tag, ".seg32"}, {seg3, seg2}, m_down ? {segtab[m_ascii[7:4]], segtab[m_ascii[3:0]]} : 16'hFFFF);
    chk({tag, ".seg54"}, {seg5, seg4}, {segtab[m_count[7:4]], segtab[m_count[3:0]]});
    chk({tag, ".seg76"}, {seg7, seg6}, 16'hFFFF);
  endtask

  logic [7:0] key;

  initial begin
    model_reset();
    wait_clk(3);
    chk("rst.ledr", ledr, 16'h01A5);
    check_all("rst");

    @(negedge clk);
    rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("led.step1", {8'h0, ledr[15:8]}, 16'h0002);
    repeat (28) @(posedge clk);
    #1 chk("led.wrap", {8'h0, ledr[15:8]}, 16'h0001);
    sw = 8'h3C;
    #1 chk("sw.mirror", {8'h0, ledr[7:0]}, 16'h003C);

    send_byte(8'h1C);
    check_all("make1c");
    chk("make1c.seg", {seg3, seg2, seg1, seg0} == 32'h82F9F9C6 ? 16'h1 : 16'h0, 16'h1);
    chk("make1c.cnt", {8'h0, seg4}, 16'h00F9);
    send_byte(8'h1C);
    send_byte(8'h1C);
    check_all("typematic");
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_all("release");

    send_frame(8'h16, 1'b1, 11);
    check_all("badpar");
    send_byte(8'h16);
    check_all("goodpar");
    chk("goodpar.ascii", {8'h0, ascii}, 16'h0031);

    send_frame(8'h45, 1'b0, 5);
    rst = 1;
    model_reset();
    #1 check_all("midrst");
    wait_clk(2);
    rst = 0;
    wait_clk(2);
    send_byte(8'h45);
    check_all("after_rst");
    chk("after_rst.cnt", {seg5, seg4}, 16'hC0F9);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: key = letters[$urandom_range(0, 25)];
        1: key = digits[$urandom_range(0, 9)];
        default: key = extras[$urandom_range(0, 3)];
      endcase
      case ($urandom_range(0, 3))
        0, 1: send_byte(key);
        2: begin send_byte(8'hF0); send_byte(key); end
        default: begin send_byte(8'hE0); send_byte(key); end
      endcase
      check_all($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_display.md
# ps2_key_display

Keyboard-and-display front end for the board top level. It receives PS/2 Set-2 scan codes and tracks the currently held key, its ASCII code and a press count. It shows these values on eight active-low seven-segment digits and drives a running-light LED bank. It sits between the board pins (ps2_clk, ps2_data, sw, btn) and the display outputs.

## Interface
- LED_PERIOD, default 5_000_000: clk cycles between LED rotation steps (≥2).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data.
- btn  in  5  reserved; ignored.
- sw  in  8  switches, mirrored to ledr[7:0].
- ledr  out  16  [7:0] = sw (combinational); [15:8] = one-hot running light.
- scan_code  out  8  last accepted make code.
- ascii  out  8  ASCII code of scan_code; 0x00 if unmapped.
- key_down  out  1  1 while a key is held.
- seg0..seg7  out  8 each  digit patterns, active-low; bit0=a … bit6=g, bit7=dp (always 1).

## Operation
- **PS/2 receiver**
  - Pass ps2_clk through a 3-flop synchronizer and detect falling edges.
  - On each falling edge, shift in ps2_data, giving an 11-bit frame: start(0), d0..d7 LSB first, odd parity, stop(1).
  - After bit 11, the frame is valid only if start=0, stop=1 and d0..d7 plus parity has odd weight.
  - Invalid frames are dropped silently. The bit counter then returns to 0.
- **Byte decode**, valid bytes only:
  - 0xE0: discarded, no state change.
  - 0xF0: sets break_pending.
  - Any other byte with break_pending=1: this is a release. Clear break_pending and set key_down=0. scan_code and ascii keep their values.
  - Any other byte with break_pending=0: this is a make. Load scan_code=byte and ascii=lookup(byte), then set key_down=1.
    - If key_down was 0 before this byte, increment press_count (8-bit, wraps 0xFF→0x00).
    - Typematic repeats arrive with key_down=1 and do not increment press_count.
- **ASCII lookup** (Set 2 to lowercase ASCII):
  - Letters a–z, e.g. 0x1C→0x61, 0x32→0x62, 0x1A→0x7A.
  - Digits 0–9: 0x45→0x30, 0x16→0x31, 0x1E→0x32, 0x26→0x33, 0x25→0x34, 0x2E→0x35, 0x36→0x36, 0x3D→0x37, 0x3E→0x38, 0x46→0x39.
  - Space 0x29→0x20; everything else →0x00.
- **Display**
  - seg1:seg0 = scan_code hex (seg0 = low nibble).
  - seg3:seg2 = ascii hex.
  - seg0..seg3 show 0xFF (blank) while key_down=0.
  - seg5:seg4 = press_count hex, always shown.
  - seg6, seg7 = 0xFF.
  - Hex patterns: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- **LEDs**
  - A counter runs 0..LED_PERIOD-1.
  - When it wraps to 0, ledr[15:8] rotates left by one (bit15→bit8).

## Timing
- **Reset** (async, immediate):
  - scan_code=0, ascii=0, key_down=0, press_count=0, break_pending=0, bit counter=0, synchronizer=all 1.
  - ledr[15:8]=0x01, LED counter=0.
  - seg0..3=0xFF, seg4=seg5=0xC0, seg6=seg7=0xFF.
- Reset in the middle of a frame discards the partial frame.
- The edge detect trails the ps2_clk fall by 3 clk cycles.
- scan_code, ascii, key_down and press_count update together, one cycle after the 11th falling edge is detected.
- Segment outputs are combinational from the registers; they add no latency.
- ledr[15:8] changes exactly every LED_PERIOD cycles after reset release.

## Structure
- Shared package holds:
  - Constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - Function hex_to_seg(4-bit)→8-bit.
  - Function scan_to_ascii(8-bit)→8-bit.
- One sub-module, ps2_rx: synchronizer, edge detect, frame shift and check. Outputs are byte[7:0] and a 1-cycle byte_valid pulse.
- Byte decode, counter, display and LED logic live in the top of the block.

## Test plan
- Reset with sw=0xA5, LED_PERIOD=4:
  - ledr=0x01A5 and seg4=seg5=0xC0 right after reset.
  - ledr[15:8]=0x02 after 4 cycles, and 0x01 again after 32 cycles.
- Send frame 0x1C:
  - scan_code=0x1C, ascii=0x61, key_down=1.
  - seg0=C6, seg1=F9, seg2=F9, seg3=82, seg4=F9 (count=1).
- Send 0x1C twice more (typematic): press_count stays 0x01.
- Send F0 then 1C:
  - key_down=0, seg0..3=0xFF, scan_code=0x1C, press_count=0x01.
- Send 0x16 with bad parity: no change. Then send it with correct parity: ascii=0x31 and press_count=0x02.
- Assert rst after 5 bits of a 0x45 frame, release, then send a full 0x45: scan_code=0x45, ascii=0x30, press_count=0x01.
